// File: rtl/seletor_interface_mostrador.sv
// Registered display selector: picks one of N_CANAIS request channels by mode
// (priority, round-robin, auto-scan, freeze) and holds each pick >= MIN_PERM cycles.
module seletor_interface_mostrador #(
  parameter  int N_CANAIS = 4,
  parameter  int LARGURA  = 8,
  parameter  int MIN_PERM = 4,
  localparam int W_SEL    = $clog2(N_CANAIS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  modo,
  input  logic [N_CANAIS-1:0]         pedido,
  input  logic [N_CANAIS*LARGURA-1:0] dados,
  output logic [W_SEL-1:0]            sel_mostrador,
  output logic [LARGURA-1:0]          dado_mostrador,
  output logic                        valido,
  output logic                        troca
);
  localparam int CW = $clog2(MIN_PERM + 1);

  typedef enum logic {OCIOSO, EXIBINDO} estado_t;

  estado_t                          estado, prox_estado;
  logic [CW-1:0]                    cnt;
  logic [N_CANAIS-1:0][LARGURA-1:0] canal;
  logic [W_SEL-1:0]                 prio_idx, rr_idx, inc_idx, prox_sel;
  logic                             rr_found, carrega, decide;

  assign canal = dados;

  always_comb begin
    prio_idx = '0;
    for (int k = N_CANAIS - 1; k >= 0; k--)
      if (pedido[k]) prio_idx = W_SEL'(k);
  end

  // Search sel+1 .. sel+N-1 with explicit wrap, so non-power-of-2 N is safe.
  always_comb begin
    int j;
    rr_found = 1'b0;
    rr_idx   = sel_mostrador;
    for (int k = 1; k < N_CANAIS; k++) begin
      j = int'(sel_mostrador) + k;
      if (j >= N_CANAIS) j = j - N_CANAIS;
      if (!rr_found && pedido[j]) begin
        rr_found = 1'b1;
        rr_idx   = W_SEL'(j);
      end
    end
  end

  assign inc_idx = (sel_mostrador == W_SEL'(N_CANAIS - 1)) ? '0 : sel_mostrador + W_SEL'(1);
  assign decide  = (estado == OCIOSO) || (cnt == CW'(MIN_PERM));

  always_comb begin
    prox_estado = estado;
    prox_sel    = sel_mostrador;
    carrega     = 1'b0;
    if (decide) begin
      if (estado == OCIOSO) begin
        case (modo)
          2'b00: if (|pedido) begin carrega = 1'b1; prox_sel = prio_idx; end
          2'b01: if (|pedido) begin carrega = 1'b1; prox_sel = rr_found ? rr_idx : sel_mostrador; end
          2'b10: begin carrega = 1'b1; prox_sel = inc_idx; end
          default: ;
        endcase
      end else begin
        case (modo)
          2'b00:
            if (!(|pedido))                     prox_estado = OCIOSO;
            else if (prio_idx != sel_mostrador) begin carrega = 1'b1; prox_sel = prio_idx; end
          2'b01:
            if (rr_found)                       begin carrega = 1'b1; prox_sel = rr_idx; end
            else if (!pedido[sel_mostrador])    prox_estado = OCIOSO;
          2'b10: begin carrega = 1'b1; prox_sel = inc_idx; end
          default: ;
        endcase
      end
    end
    if (carrega) prox_estado = EXIBINDO;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= OCIOSO;
      sel_mostrador  <= '0;
      dado_mostrador <= '0;
      valido         <= 1'b0;
      troca          <= 1'b0;
      cnt            <= '0;
    end else begin
      estado         <= prox_estado;
      sel_mostrador  <= prox_sel;
      troca          <= carrega;
      valido         <= (prox_estado == EXIBINDO);
      dado_mostrador <= (prox_estado == EXIBINDO) ? canal[prox_sel] : '0;
      // A "stay" keeps cnt saturated, so the next decision is immediate.
      if (carrega)
        cnt <= CW'(1);
      else if (estado == EXIBINDO && cnt != CW'(MIN_PERM))
        cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_seletor_interface_mostrador.sv
// Directed bench: a 4-channel instance for priority/round-robin/drop/freeze and a
// 3-channel instance for auto-scan wrap and mid-hold reset.
module tb_seletor_interface_mostrador;
  logic        clock = 1'b0;
  logic        reset, reset3;
  logic [1:0]  modo, modo3;
  logic [3:0]  pedido;
  logic [2:0]  pedido3;
  logic [31:0] dados;
  logic [23:0] dados3;
  logic [1:0]  sel, sel3;
  logic [7:0]  dado, dado3;
  logic        valido, valido3, troca, troca3;

  int total = 0;
  int bad   = 0;

  seletor_interface_mostrador #(.N_CANAIS(4), .LARGURA(8), .MIN_PERM(4)) dut (
    .clock(clock), .reset(reset), .modo(modo), .pedido(pedido), .dados(dados),
    .sel_mostrador(sel), .dado_mostrador(dado), .valido(valido), .troca(troca));

  seletor_interface_mostrador #(.N_CANAIS(3), .LARGURA(8), .MIN_PERM(4)) dut3 (
    .clock(clock), .reset(reset3), .modo(modo3), .pedido(pedido3), .dados(dados3),
    .sel_mostrador(sel3), .dado_mostrador(dado3), .valido(valido3), .troca(troca3));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] s, input logic [7:0] d,
                      input logic v, input logic t);
    chk({tag, "_sel"},    {30'd0, sel},    {30'd0, s});
    chk({tag, "_dado"},   {24'd0, dado},   {24'd0, d});
    chk({tag, "_valido"}, {31'd0, valido}, {31'd0, v});
    chk({tag, "_troca"},  {31'd0, troca},  {31'd0, t});
  endtask

  task automatic chk3(input string tag, input logic [1:0] s, input logic [7:0] d,
                      input logic v, input logic t);
    chk({tag, "_sel3"},    {30'd0, sel3},    {30'd0, s});
    chk({tag, "_dado3"},   {24'd0, dado3},   {24'd0, d});
    chk({tag, "_valido3"}, {31'd0, valido3}, {31'd0, v});
    chk({tag, "_troca3"},  {31'd0, troca3},  {31'd0, t});
  endtask

  initial begin
    logic [1:0] rr_seq [4];
    logic [1:0] scan_seq [3];
    rr_seq   = '{2'd1, 2'd2, 2'd3, 2'd0};
    scan_seq = '{2'd1, 2'd2, 2'd0};

    dados   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    dados3  = {8'hB2, 8'hB1, 8'hB0};
    reset3  = 1'b1; modo3 = 2'b10; pedido3 = 3'b000;

    // 1: reset with all requests pending
    reset = 1'b1; modo = 2'b00; pedido = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("t1_rst", 2'd0, 8'h00, 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick();
    chk4("t1_rel", 2'd0, 8'hA0, 1'b1, 1'b1);

    // 2: priority hold, lower request arrives on the 2nd display cycle
    reset = 1'b1; pedido = 4'b0100;
    tick();
    reset = 1'b0;
    tick();
    chk4("t2_load2", 2'd2, 8'hA2, 1'b1, 1'b1);
    pedido = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("t2_hold2", 2'd2, 8'hA2, 1'b1, 1'b0);
    end
    tick();
    chk4("t2_load0", 2'd0, 8'hA0, 1'b1, 1'b1);

    // 3: round-robin 0,1,2,3,0
    modo = 2'b01; pedido = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("t3_hold0", 2'd0, 8'hA0, 1'b1, 1'b0);
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      chk4("t3_load", rr_seq[g], 8'hA0 + {6'd0, rr_seq[g]}, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk4("t3_hold", rr_seq[g], 8'hA0 + {6'd0, rr_seq[g]}, 1'b1, 1'b0);
      end
    end

    // 5a: request drops during hold; hold completes, then idle with sel kept
    pedido = 4'b0010;
    tick();
    chk4("t5_load1", 2'd1, 8'hA1, 1'b1, 1'b1);
    pedido = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("t5_hold1", 2'd1, 8'hA1, 1'b1, 1'b0);
    end
    tick();
    chk4("t5_idle", 2'd1, 8'h00, 1'b0, 1'b0);
    tick();
    chk4("t5_idle2", 2'd1, 8'h00, 1'b0, 1'b0);

    // 5b: reload same index from idle, then freeze against other requests
    pedido = 4'b0010;
    tick();
    chk4("t5_reload1", 2'd1, 8'hA1, 1'b1, 1'b1);
    modo = 2'b11; pedido = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk4("t5_freeze", 2'd1, 8'hA1, 1'b1, 1'b0);
    end

    // 4: auto-scan on 3 channels, no requests
    reset3 = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk3("t4_load", scan_seq[g], 8'hB0 + {6'd0, scan_seq[g]}, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk3("t4_hold", scan_seq[g], 8'hB0 + {6'd0, scan_seq[g]}, 1'b1, 1'b0);
      end
    end
    tick();
    chk3("t4_wrap1", 2'd1, 8'hB1, 1'b1, 1'b1);
    tick();
    chk3("t4_mid", 2'd1, 8'hB1, 1'b1, 1'b0);

    // 6: reset in the middle of the hold, scan restarts at 1
    reset3 = 1'b1;
    tick();
    chk3("t6_rst", 2'd0, 8'h00, 1'b0, 1'b0);
    reset3 = 1'b0;
    tick();
    chk3("t6_load1", 2'd1, 8'hB1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3("t6_hold1", 2'd1, 8'hB1, 1'b1, 1'b0);
    end
    tick();
    chk3("t6_load2", 2'd2, 8'hB2, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
